leg_mem_arbiter: RTL and testbench
==================================

Name: leg_mem_arbiter

Overview:
- Owns the processor's byte-addressed scratch/program memory (single port, 2^ADDR_W x DATA_W).
- Shares that memory between two requesters: port 0 is the processor core (instruction fetch and operand access), port 1 is the loader/debug path (firmware load, LED/memory inspection).
- Arbitration is round-robin, with a bounded lock so a 2-byte instruction fetch is not split by the other port.

Parameters:
- ADDR_W, 5: address width; memory depth is 2^ADDR_W bytes.
- DATA_W, 8: data width of each memory word.
- MAX_LOCK, 4: maximum consecutive locked grants to one port before a forced release; must be >= 1.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- req0  input  1  port 0 access request.
- we0  input  1  port 0 write enable; 1 = write, 0 = read.
- addr0  input  ADDR_W  port 0 byte address.
- wdata0  input  DATA_W  port 0 write data.
- lock0  input  1  port 0 requests to keep ownership after this grant.
- gnt0  output  1  port 0 access performed at this clock edge (combinational).
- rvalid0  output  1  port 0 read data valid; one-cycle pulse.
- rdata0  output  DATA_W  port 0 read data.
- req1, we1, addr1, wdata1, lock1, gnt1, rvalid1, rdata1: same meanings for port 1.
- owner  output  1  port granted most recently (registered).

Behaviour:
- Reset, synchronous:
  - gnt0/gnt1 = 0 while rst = 1.
  - rvalid0/rvalid1 = 0; rdata0/rdata1 = 0.
  - owner = 1, so port 0 wins the first contention.
  - Lock flag and lock counter cleared.
  - Memory contents are NOT reset, so loaded firmware survives a core reset.
- Grant logic (combinational, from current inputs and registered state):
  - At most one gnt per cycle; gnt never asserted without the matching req.
  - Locked, owner requesting, lock count < MAX_LOCK: owner granted.
  - Locked, owner not requesting: lock dropped and normal arbitration applies this cycle.
  - Unlocked, only one port requesting: that port granted.
  - Unlocked, both requesting: the port != owner is granted (round-robin).
  - Locked, lock count == MAX_LOCK, other port requesting: other port granted; lock cleared.
  - Locked, lock count == MAX_LOCK, other port idle: owner granted; counter restarts at 1.
- Access at the grant edge:
  - Write: mem[addr] <= wdata.
  - Read: rdata <= mem[addr]; rvalid pulses for exactly one cycle, the cycle after gnt.
  - rdata holds its last value until the next read to that port.
  - The non-granted port's rvalid is 0.
- Registered state update at each grant:
  - owner <= granted port.
  - Lock flag <= lock of the granted port.
  - Lock count <= count + 1 if the same port is granted while locked, otherwise 1 if that port's lock = 1, otherwise 0.
  - No grant (no requests): owner, lock flag and count hold.
- Latency:
  - Grant: 0 cycles.
  - Read data: 1 cycle.
  - Back-to-back requests from one port: serviced every cycle when uncontended.
- Boundary conditions:
  - Addresses wrap naturally; every ADDR_W value is valid.
  - Same-address write from one port and read from the other cannot collide (single port). A read granted the cycle after a write returns the new data.
  - Requester must hold req/addr/we/wdata stable until it sees gnt. Changing them before gnt is allowed: the arbiter uses current values, with no internal queue.
  - rst asserted the cycle after a read grant: rvalid stays 0 and the pending read is discarded.
  - MAX_LOCK = 1: lock never blocks a requesting other port for more than one grant.

Test Plan:
- Reset: hold rst 2 cycles with req0 = req1 = 1 -> gnt0 = gnt1 = 0, rvalid0 = rvalid1 = 0, owner = 1. First cycle after release -> gnt0 = 1.
- Write/read across ports: port1 writes addr 3 = 0x5A (gnt1 = 1). Next cycle port0 reads addr 3 -> gnt0 = 1, then rvalid0 = 1 with rdata0 = 0x5A one cycle later. rvalid1 stays 0.
- Round-robin: both ports read continuously from reset, no lock -> grants 0,1,0,1,0,1. Each rvalid follows its gnt by exactly 1 cycle.
- Locked fetch: port0 reads addr 16 (lock0 = 1), then addr 17 (lock0 = 0) while req1 = 1 throughout -> gnt0 on 2 consecutive cycles, gnt1 on the third. rdata0 = mem[16] then mem[17].
- Lock limit (MAX_LOCK = 4): port0 requests with lock0 = 1 for 8 cycles while req1 = 1 -> gnt0 x4, gnt1 x1, then gnt0 resumes.
- Reset mid-read: port1 read granted at cycle N, rst = 1 at cycle N+1 -> rvalid1 = 0 at N+1 and N+2. A memory location written before reset still reads back its old value after reset.

Source files
------------

// File: rtl/leg_mem_arbiter.sv
// Purpose: single-port byte memory shared by core (port 0) and loader (port 1), round-robin with bounded lock.
// Latency: grant is combinational (0 cycles); read data and rvalid arrive 1 cycle after the grant.
// Backpressure: a requester is stalled simply by not seeing gnt; it must hold its request until granted.
module leg_mem_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8,
    parameter int MAX_LOCK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              lock0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              owner
);

    localparam int                CNT_W   = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_LOCK);
    localparam logic [CNT_W-1:0]  ONE_CNT = CNT_W'(1);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic              owner_q;
    logic              lock_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              rvalid0_q;
    logic              rvalid1_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    logic              owner_req;
    logic              other_req;
    logic              restart;
    logic              gnt_any;
    logic              gsel;
    logic              lock_sel;
    logic              we_sel;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;
    logic              same_locked;

    // Grant decision: honour an active lock up to MAX_LOCK grants, otherwise round-robin.
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        restart   = 1'b0;
        owner_req = owner_q ? req1 : req0;
        other_req = owner_q ? req0 : req1;
        if (!rst) begin
            if (lock_q && owner_req) begin
                if ((cnt_q < MAX_CNT) || !other_req) begin
                    // Owner keeps the memory; at the limit with an idle peer the count restarts.
                    restart = (cnt_q >= MAX_CNT);
                    gnt0    = !owner_q;
                    gnt1    = owner_q;
                end else begin
                    // Limit reached and the peer is waiting: forced hand-over.
                    gnt0 = owner_q;
                    gnt1 = !owner_q;
                end
            end else if (req0 && req1) begin
                gnt0 = owner_q;
                gnt1 = !owner_q;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign gnt_any     = gnt0 | gnt1;
    assign gsel        = gnt1;
    assign lock_sel    = gsel ? lock1  : lock0;
    assign we_sel      = gsel ? we1    : we0;
    assign addr_sel    = gsel ? addr1  : addr0;
    assign wdata_sel   = gsel ? wdata1 : wdata0;
    assign same_locked = lock_q && (gsel == owner_q) && !restart;

    // Ownership, lock flag and lock counter update on every grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= 1'b1;
            lock_q  <= 1'b0;
            cnt_q   <= '0;
        end else if (gnt_any) begin
            owner_q <= gsel;
            lock_q  <= lock_sel;
            if (same_locked) begin
                cnt_q <= cnt_q + ONE_CNT;
            end else begin
                cnt_q <= lock_sel ? ONE_CNT : '0;
            end
        end else if (lock_q && !owner_req) begin
            // Owner walked away from its lock with nobody else asking.
            lock_q <= 1'b0;
            cnt_q  <= '0;
        end
    end

    // Memory write port; contents deliberately survive reset so loaded firmware persists.
    always_ff @(posedge clk) begin
        if (gnt_any && we_sel) begin
            mem[addr_sel] <= wdata_sel;
        end
    end

    // Per-port read data capture and one-cycle valid pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= gnt0 && !we0;
            rvalid1_q <= gnt1 && !we1;
            if (gnt0 && !we0) begin
                rdata0_q <= mem[addr0];
            end
            if (gnt1 && !we1) begin
                rdata1_q <= mem[addr1];
            end
        end
    end

    // A read completing into a reset cycle is discarded, so valid is masked by rst.
    assign rvalid0 = rvalid0_q && !rst;
    assign rvalid1 = rvalid1_q && !rst;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;
    assign owner   = owner_q;

endmodule

// File: tb/tb_leg_mem_arbiter.sv
// Purpose: directed table-driven bench for leg_mem_arbiter plus lock-limit and reset-mid-read sequences.
// Latency: inputs change 1 time unit after posedge; outputs are sampled on the following negedge.
// Backpressure: requests are held or changed by the stimulus table exactly as listed.
module tb_leg_mem_arbiter;

    logic       clk;
    logic       rst;
    logic       req0, we0, lock0, req1, we1, lock1;
    logic [4:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;

    logic       gnt0, gnt1, rvalid0, rvalid1, owner;
    logic [7:0] rdata0, rdata1;

    logic       l1_gnt0, l1_gnt1, l1_rvalid0, l1_rvalid1, l1_owner;
    logic [7:0] l1_rdata0, l1_rdata1;

    int n_chk;
    int n_err;

    leg_mem_arbiter #(.ADDR_W(5), .DATA_W(8), .MAX_LOCK(4)) u_dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .owner(owner)
    );

    leg_mem_arbiter #(.ADDR_W(5), .DATA_W(8), .MAX_LOCK(1)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
        .gnt0(l1_gnt0), .rvalid0(l1_rvalid0), .rdata0(l1_rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
        .gnt1(l1_gnt1), .rvalid1(l1_rvalid1), .rdata1(l1_rdata1),
        .owner(l1_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       r0, w0, l0;
        logic [4:0] a0;
        logic [7:0] d0;
        logic       r1, w1, l1;
        logic [4:0] a1;
        logic [7:0] d1;
        logic       g0, g1, rv0, rv1, own;
        logic [7:0] rd0, rd1;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rs,
                       input logic r0, input logic w0, input logic [4:0] a0, input logic [7:0] d0, input logic l0,
                       input logic r1, input logic w1, input logic [4:0] a1, input logic [7:0] d1, input logic l1,
                       input logic g0, input logic g1, input logic rv0, input logic rv1, input logic own,
                       input logic [7:0] rd0, input logic [7:0] rd1);
        vec_t v;
        v.rst = rs;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.l0 = l0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.l1 = l1;
        v.g0 = g0; v.g1 = g1; v.rv0 = rv0; v.rv1 = rv1; v.own = own;
        v.rd0 = rd0; v.rd1 = rd1;
        vq.push_back(v);
    endtask

    task automatic drive(input logic rs,
                         input logic r0, input logic w0, input logic [4:0] a0, input logic [7:0] d0, input logic l0,
                         input logic r1, input logic w1, input logic [4:0] a1, input logic [7:0] d1, input logic l1);
        rst = rs;
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0; lock0 = l0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1; lock1 = l1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        drive(1'b1, 0,0,5'd0,8'h00,0, 0,0,5'd0,8'h00,0);
        next_cycle();

        //   rst r0 w0 a0     d0    l0  r1 w1 a1     d1    l1 | g0 g1 rv0 rv1 own rd0    rd1
        add(1, 1,0,5'd0, 8'h00,0, 1,0,5'd3, 8'h00,0, 0,0,0,0,1, 8'h00,8'h00);
        add(1, 1,0,5'd0, 8'h00,0, 1,0,5'd3, 8'h00,0, 0,0,0,0,1, 8'h00,8'h00);
        add(0, 1,1,5'd0, 8'h11,0, 1,1,5'd3, 8'h5A,0, 1,0,0,0,1, 8'h00,8'h00);
        add(0, 0,0,5'd0, 8'h00,0, 1,1,5'd3, 8'h5A,0, 0,1,0,0,0, 8'h00,8'h00);
        add(0, 1,0,5'd3, 8'h00,0, 0,0,5'd0, 8'h00,0, 1,0,0,0,1, 8'h00,8'h00);
        add(0, 0,0,5'd0, 8'h00,0, 0,0,5'd0, 8'h00,0, 0,0,1,0,0, 8'h5A,8'h00);
        add(0, 1,1,5'd17,8'h71,0, 1,1,5'd16,8'hA6,0, 0,1,0,0,0, 8'h5A,8'h00);
        add(0, 1,1,5'd17,8'h71,0, 0,0,5'd0, 8'h00,0, 1,0,0,0,1, 8'h5A,8'h00);
        add(1, 1,0,5'd0, 8'h00,0, 1,0,5'd3, 8'h00,0, 0,0,0,0,0, 8'h5A,8'h00);
        add(0, 1,0,5'd0, 8'h00,0, 1,0,5'd3, 8'h00,0, 1,0,0,0,1, 8'h00,8'h00);
        add(0, 1,0,5'd0, 8'h00,0, 1,0,5'd3, 8'h00,0, 0,1,1,0,0, 8'h11,8'h00);
        add(0, 1,0,5'd0, 8'h00,0, 1,0,5'd3, 8'h00,0, 1,0,0,1,1, 8'h11,8'h5A);
        add(0, 1,0,5'd0, 8'h00,0, 1,0,5'd3, 8'h00,0, 0,1,1,0,0, 8'h11,8'h5A);
        add(0, 0,0,5'd0, 8'h00,0, 0,0,5'd0, 8'h00,0, 0,0,0,1,1, 8'h11,8'h5A);
        add(0, 1,0,5'd16,8'h00,1, 1,0,5'd0, 8'h00,0, 1,0,0,0,1, 8'h11,8'h5A);
        add(0, 1,0,5'd17,8'h00,0, 1,0,5'd0, 8'h00,0, 1,0,1,0,0, 8'hA6,8'h5A);
        add(0, 0,0,5'd0, 8'h00,0, 1,0,5'd0, 8'h00,0, 0,1,1,0,0, 8'h71,8'h5A);
        add(0, 0,0,5'd0, 8'h00,0, 0,0,5'd0, 8'h00,0, 0,0,0,1,1, 8'h71,8'h11);

        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].r0, vq[i].w0, vq[i].a0, vq[i].d0, vq[i].l0,
                  vq[i].r1, vq[i].w1, vq[i].a1, vq[i].d1, vq[i].l1);
            @(negedge clk);
            chk($sformatf("row%0d gnt0", i),    {7'd0, gnt0},    {7'd0, vq[i].g0});
            chk($sformatf("row%0d gnt1", i),    {7'd0, gnt1},    {7'd0, vq[i].g1});
            chk($sformatf("row%0d rvalid0", i), {7'd0, rvalid0}, {7'd0, vq[i].rv0});
            chk($sformatf("row%0d rvalid1", i), {7'd0, rvalid1}, {7'd0, vq[i].rv1});
            chk($sformatf("row%0d owner", i),   {7'd0, owner},   {7'd0, vq[i].own});
            chk($sformatf("row%0d rdata0", i),  rdata0,          vq[i].rd0);
            chk($sformatf("row%0d rdata1", i),  rdata1,          vq[i].rd1);
            next_cycle();
        end

        // Lock limit: port 0 holds lock for 8 cycles against a constantly requesting port 1.
        begin
            logic [7:0] exp_g0_m4;
            logic [7:0] exp_g0_m1;
            exp_g0_m4 = 8'b1110_1111;   // bit i = cycle i: four grants, hand-over, then resume
            exp_g0_m1 = 8'b0101_0101;   // MAX_LOCK=1 alternates every grant
            drive(1'b1, 0,0,5'd0,8'h00,0, 0,0,5'd0,8'h00,0);
            next_cycle();
            for (int c = 0; c < 8; c++) begin
                drive(1'b0, 1,0,5'd16,8'h00,1, 1,0,5'd0,8'h00,0);
                @(negedge clk);
                chk($sformatf("lock4 c%0d gnt0", c), {7'd0, gnt0},    {7'd0, exp_g0_m4[c]});
                chk($sformatf("lock4 c%0d gnt1", c), {7'd0, gnt1},    {7'd0, ~exp_g0_m4[c]});
                chk($sformatf("lock1 c%0d gnt0", c), {7'd0, l1_gnt0}, {7'd0, exp_g0_m1[c]});
                chk($sformatf("lock1 c%0d gnt1", c), {7'd0, l1_gnt1}, {7'd0, ~exp_g0_m1[c]});
                next_cycle();
            end
        end

        // Reset arriving the cycle after a read grant discards that read; memory survives.
        drive(1'b0, 0,0,5'd0,8'h00,0, 1,0,5'd3,8'h00,0);
        @(negedge clk);
        chk("rstrd gnt1 N", {7'd0, gnt1}, 8'd1);
        next_cycle();
        drive(1'b1, 0,0,5'd0,8'h00,0, 0,0,5'd0,8'h00,0);
        @(negedge clk);
        chk("rstrd rvalid1 N+1", {7'd0, rvalid1}, 8'd0);
        next_cycle();
        drive(1'b0, 0,0,5'd0,8'h00,0, 0,0,5'd0,8'h00,0);
        @(negedge clk);
        chk("rstrd rvalid1 N+2", {7'd0, rvalid1}, 8'd0);
        chk("rstrd rdata1 N+2",  rdata1,          8'h00);
        chk("rstrd owner N+2",   {7'd0, owner},   8'd1);
        next_cycle();
        drive(1'b0, 1,0,5'd3,8'h00,0, 1,0,5'd16,8'h00,0);
        @(negedge clk);
        chk("post-rst gnt0", {7'd0, gnt0}, 8'd1);
        next_cycle();
        drive(1'b0, 0,0,5'd0,8'h00,0, 1,0,5'd16,8'h00,0);
        @(negedge clk);
        chk("post-rst rvalid0", {7'd0, rvalid0}, 8'd1);
        chk("post-rst rdata0",  rdata0,          8'h5A);
        chk("post-rst gnt1",    {7'd0, gnt1},    8'd1);
        next_cycle();
        drive(1'b0, 0,0,5'd0,8'h00,0, 0,0,5'd0,8'h00,0);
        @(negedge clk);
        chk("post-rst rvalid1", {7'd0, rvalid1}, 8'd1);
        chk("post-rst rdata1",  rdata1,          8'hA6);
        chk("post-rst rvalid0", {7'd0, rvalid0}, 8'd0);
        next_cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
